// File: rtl/demo_nios2_gen2_0_cpu_debug_mem_master_pkg.sv
// -----------------------------------------------------------------------------
// demo_nios2_gen2_0_cpu_debug_mem_master_pkg
//
// Shared definitions for the debug memory master. These are the controller
// state encoding, the bit positions of the fields inside the 38-bit jdo
// command word, and the address step used by auto-increment.
// -----------------------------------------------------------------------------
package demo_nios2_gen2_0_cpu_debug_mem_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR_REQ  = 2'd3
  } state_e;

  localparam int JDO_WIDTH     = 38;
  localparam int JDO_ADDR_MSB  = 31;  // word address jdo[31:2]
  localparam int JDO_ADDR_LSB  = 2;
  localparam int JDO_AUTOINC   = 34;
  localparam int JDO_RDNOW     = 35;
  localparam int JDO_CLRERR    = 37;
  localparam int JDO_WDATA_MSB = 35;  // write data jdo[35:4]
  localparam int JDO_WDATA_LSB = 4;

  localparam int ADDR_INC = 4;        // one 32-bit word

endpackage

// File: rtl/demo_nios2_gen2_0_cpu_debug_mem_master_if.sv
// -----------------------------------------------------------------------------
// demo_nios2_gen2_0_cpu_debug_mem_master_if
//
// Avalon-MM master bus bundle between the debug memory master and system
// memory.
//   master modport : drives address/read/write/writedata/byteenable and
//                    samples waitrequest/readdata/readdatavalid.
//   slave  modport : the mirror image, used by the memory side.
// -----------------------------------------------------------------------------
interface demo_nios2_gen2_0_cpu_debug_mem_master_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] avm_address;
  logic                  avm_read;
  logic                  avm_write;
  logic [31:0]           avm_writedata;
  logic [3:0]            avm_byteenable;
  logic                  avm_waitrequest;
  logic [31:0]           avm_readdata;
  logic                  avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/demo_nios2_gen2_0_cpu_debug_mem_timeout.sv
// -----------------------------------------------------------------------------
// demo_nios2_gen2_0_cpu_debug_mem_timeout
//
// Watchdog counter for one bus phase. clr_i reloads the count with zero
// and en_i advances it by one per cycle. expired_o is raised in the cycle
// whose increment would reach TIMEOUT_CYCLES, so the owner can abandon the
// phase at that same edge. The request is then held for exactly
// TIMEOUT_CYCLES cycles.
//   clk, reset_n : clock, synchronous active-low reset
//   clr_i        : reload count with zero (has priority over en_i)
//   en_i         : count this cycle
//   expired_o    : phase time budget used up
// -----------------------------------------------------------------------------
module demo_nios2_gen2_0_cpu_debug_mem_timeout #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TMO_WIDTH      = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TMO_WIDTH-1:0] LAST_CNT = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TMO_WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every variable gets its default at the top of always_comb, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TMO_WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/demo_nios2_gen2_0_cpu_debug_mem_master.sv
// -----------------------------------------------------------------------------
// demo_nios2_gen2_0_cpu_debug_mem_master
//
// Turns decoded JTAG debug commands into single Avalon-MM reads or writes
// and returns the result to the debug slave. There is never more than one
// transaction in flight, and a per-phase watchdog aborts a bus that stalls.
//   clk, reset_n            : system clock, synchronous active-low reset
//   jdo                     : command/data word from the debug slave
//   take_action_ocimem_a    : load address/autoinc, optional read/clear
//   take_action_ocimem_b    : write jdo[35:4] at the current address
//   take_no_action_ocimem_a : read at the current address
//   avm                     : Avalon-MM master bus (interface, master side)
//   MonDReg                 : last read data
//   monitor_ready           : last command finished
//   monitor_error           : sticky error (timeout or command overrun)
//   busy                    : transaction in progress
// -----------------------------------------------------------------------------
module demo_nios2_gen2_0_cpu_debug_mem_master
  import demo_nios2_gen2_0_cpu_debug_mem_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TMO_WIDTH      = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [JDO_WIDTH-1:0] jdo,
  input  logic                 take_action_ocimem_a,
  input  logic                 take_action_ocimem_b,
  input  logic                 take_no_action_ocimem_a,
  demo_nios2_gen2_0_cpu_debug_mem_master_if.master avm,
  output logic [31:0]          MonDReg,
  output logic                 monitor_ready,
  output logic                 monitor_error,
  output logic                 busy
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           mon_q, mon_d;
  logic                  autoinc_q, autoinc_d;
  logic                  ready_q, ready_d;
  logic                  error_q, error_d;
  logic                  overrun_q, overrun_d;
  logic                  busy_q, busy_d;

  logic start_rd, start_wr, done, abort, err_clr, any_strobe;
  logic tmo_expired;

  // These jdo bits carry nothing for the memory master.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[36], jdo[1:0]};

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b |
                      take_no_action_ocimem_a;

  demo_nios2_gen2_0_cpu_debug_mem_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMO_WIDTH     (TMO_WIDTH)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (state_d != state_q),  // restart the budget on every state entry
    .en_i     (state_q != ST_IDLE),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mon_d     = mon_q;
    autoinc_d = autoinc_q;
    ready_d   = ready_q;
    error_d   = error_q;
    overrun_d = overrun_q;
    busy_d    = busy_q;
    start_rd  = 1'b0;
    start_wr  = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    err_clr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Strobe priority: a > b > no_action_a.
        if (take_action_ocimem_a) begin
          addr_d    = ADDR_WIDTH'({jdo[JDO_ADDR_MSB:JDO_ADDR_LSB], 2'b00});
          autoinc_d = jdo[JDO_AUTOINC];
          err_clr   = jdo[JDO_CLRERR];
          start_rd  = jdo[JDO_RDNOW];
        end else if (take_action_ocimem_b) begin
          wdata_d  = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
          start_wr = 1'b1;
        end else if (take_no_action_ocimem_a) begin
          start_rd = 1'b1;
        end
      end
      ST_RD_REQ: begin
        // A completed bus step wins over a watchdog that expires in the same cycle.
        if (!avm.avm_waitrequest) begin
          if (avm.avm_readdatavalid) begin
            mon_d = avm.avm_readdata;   // zero-latency slave: done at acceptance
            done  = 1'b1;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end else if (tmo_expired) begin
          abort = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (avm.avm_readdatavalid) begin
          mon_d = avm.avm_readdata;
          done  = 1'b1;
        end else if (tmo_expired) begin
          abort = 1'b1;
        end
      end
      ST_WR_REQ: begin
        if (!avm.avm_waitrequest) begin
          done = 1'b1;
        end else if (tmo_expired) begin
          abort = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_rd) begin
      state_d = ST_RD_REQ;
      ready_d = 1'b0;
      busy_d  = 1'b1;
    end
    if (start_wr) begin
      state_d = ST_WR_REQ;
      ready_d = 1'b0;
      busy_d  = 1'b1;
    end
    if (done) begin
      state_d = ST_IDLE;
      ready_d = 1'b1;
      busy_d  = 1'b0;
      if (autoinc_q) begin
        addr_d = addr_q + ADDR_WIDTH'(ADDR_INC);  // wraps modulo 2^ADDR_WIDTH
      end
    end
    if (abort) begin
      // Read data and address are left untouched on a timeout.
      state_d = ST_IDLE;
      ready_d = 1'b1;
      busy_d  = 1'b0;
      error_d = 1'b1;
    end

    // A command arriving mid-transaction is dropped and flagged; a clear
    // request is still honoured.
    if (state_q != ST_IDLE) begin
      if (take_action_ocimem_a && jdo[JDO_CLRERR]) begin
        err_clr = 1'b1;
      end else if (any_strobe) begin
        error_d   = 1'b1;
        overrun_d = 1'b1;
      end
    end

    // Clearing outranks any error raised in the same cycle.
    if (err_clr) begin
      error_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      mon_q     <= '0;
      autoinc_q <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mon_q     <= mon_d;
      autoinc_q <= autoinc_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  // Requests decode straight from the state register, so address, data and
  // strobe stay frozen for as long as waitrequest holds the state.
  assign avm.avm_address    = addr_q;
  assign avm.avm_read       = (state_q == ST_RD_REQ);
  assign avm.avm_write      = (state_q == ST_WR_REQ);
  assign avm.avm_writedata  = wdata_q;
  assign avm.avm_byteenable = 4'hF;

  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_demo_nios2_gen2_0_cpu_debug_mem_master.sv
// -----------------------------------------------------------------------------
// tb_demo_nios2_gen2_0_cpu_debug_mem_master
//
// Directed scenarios followed by randomized command streams against a
// transaction-level reference model. A behavioural Avalon slave with
// programmable wait states and read latency serves the DUT.
// -----------------------------------------------------------------------------
module tb_demo_nios2_gen2_0_cpu_debug_mem_master;

  localparam int K_A = 1;  // take_action_ocimem_a
  localparam int K_B = 2;  // take_action_ocimem_b
  localparam int K_N = 3;  // take_no_action_ocimem_a

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, busy;

  demo_nios2_gen2_0_cpu_debug_mem_master_if #(.ADDR_WIDTH(32)) avm_if ();

  demo_nios2_gen2_0_cpu_debug_mem_master #(
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(15),
    .TMO_WIDTH     (4)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .avm                    (avm_if),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Background memory content for never-written words.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // ---------------------------------------------------------------- slave
  logic [31:0] slave_mem [logic [31:0]];
  txn_t        log_q [$];
  int          s_wait = 0;   // waitrequest cycles per request
  int          s_lat  = 1;   // readdatavalid delay after acceptance (0 = same cycle)
  bit          s_hang = 0;   // never accept

  initial begin
    int          waited = 0;
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = '0;
    logic [31:0] cap_addr = '0, cap_data = '0;
    logic        cap_wr = 1'b0;
    logic [31:0] d;
    avm_if.avm_waitrequest   = 1'b0;
    avm_if.avm_readdata      = '0;
    avm_if.avm_readdatavalid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      avm_if.avm_readdatavalid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          avm_if.avm_readdatavalid = 1'b1;
          avm_if.avm_readdata      = pend_data;
          pend = 0;
        end else begin
          pend_cnt--;
        end
      end
      if (avm_if.avm_read || avm_if.avm_write) begin
        if (waited == 0) begin
          cap_addr = avm_if.avm_address;
          cap_data = avm_if.avm_writedata;
          cap_wr   = avm_if.avm_write;
        end else begin
          check("hold_addr", avm_if.avm_address, cap_addr);
          check("hold_wr", avm_if.avm_write, cap_wr);
          if (cap_wr) check("hold_wdata", avm_if.avm_writedata, cap_data);
        end
        if (s_hang || waited < s_wait) begin
          avm_if.avm_waitrequest = 1'b1;
          waited++;
        end else begin
          avm_if.avm_waitrequest = 1'b0;
          waited = 0;
          if (avm_if.avm_write) begin
            slave_mem[avm_if.avm_address] = avm_if.avm_writedata;
            log_q.push_back('{1'b1, avm_if.avm_address, avm_if.avm_writedata});
          end else begin
            d = slave_mem.exists(avm_if.avm_address) ? slave_mem[avm_if.avm_address]
                                                     : init_word(avm_if.avm_address);
            log_q.push_back('{1'b0, avm_if.avm_address, d});
            if (s_lat == 0) begin
              avm_if.avm_readdatavalid = 1'b1;
              avm_if.avm_readdata      = d;
            end else begin
              pend      = 1;
              pend_cnt  = s_lat - 1;
              pend_data = d;
            end
          end
        end
      end else begin
        avm_if.avm_waitrequest = 1'b0;
        waited = 0;
      end
    end
  end

  // ---------------------------------------------------------------- model
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] m_addr, m_mon;
  bit          m_autoinc, m_ready, m_err;

  task automatic model_reset();
    m_addr = '0; m_mon = '0; m_autoinc = 0; m_ready = 0; m_err = 0;
  endtask

  // Applies one idle-state command and returns the bus transaction it must cause.
  task automatic model_cmd(input int kind, input logic [37:0] j, output bit has, output txn_t e);
    has = 0;
    e   = '{1'b0, 32'h0, 32'h0};
    if (kind == K_A) begin
      m_addr    = {j[31:2], 2'b00};
      m_autoinc = j[34];
      if (j[37]) m_err = 0;
      has = j[35];
    end else if (kind == K_B) begin
      has    = 1;
      e.wr   = 1'b1;
      e.data = j[35:4];
    end else begin
      has = 1;
    end
    if (has) begin
      e.addr = m_addr;
      if (e.wr) begin
        model_mem[m_addr] = e.data;
      end else begin
        m_mon = model_mem.exists(m_addr) ? model_mem[m_addr] : init_word(m_addr);
      end
      m_ready = 1;
      if (m_autoinc) m_addr = m_addr + 32'd4;
    end
  endtask

  function automatic logic [37:0] make_a(input logic [31:0] a, input bit inc, input bit rd,
                                         input bit clr);
    logic [37:0] j;
    j = '0;
    j[31:0] = a;
    j[34] = inc;
    j[35] = rd;
    j[37] = clr;
    return j;
  endfunction

  function automatic logic [37:0] make_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[35:4] = d;
    return j;
  endfunction

  // ---------------------------------------------------------------- driving
  // Called on a falling edge; returns on the next one with strobes released.
  task automatic drive(input int kind, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a    = (kind == K_A);
    take_action_ocimem_b    = (kind == K_B);
    take_no_action_ocimem_a = (kind == K_N);
    @(negedge clk);
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 1;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("wait_idle_bound", busy, 1'b0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_mondreg"}, MonDReg, m_mon);
    check({tag, "_ready"}, monitor_ready, m_ready);
    check({tag, "_error"}, monitor_error, m_err);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  // One command, optionally followed by a second strobe while the first is busy.
  task automatic run(input string tag, input int kind, input logic [37:0] j, input int xk,
                     input logic [37:0] xj, output int cyc);
    bit   has;
    txn_t e, t;
    model_cmd(kind, j, has, e);
    drive(kind, j);
    if (xk != 0 && has) begin
      drive(xk, xj);
      if (xk == K_A && xj[37]) m_err = 0;
      else m_err = 1;
    end
    wait_idle(cyc);
    check({tag, "_txn_count"}, log_q.size(), has);
    if (has && log_q.size() > 0) begin
      t = log_q.pop_front();
      check({tag, "_txn_op"}, t.wr, e.wr);
      check({tag, "_txn_addr"}, t.addr, e.addr);
      if (e.wr) check({tag, "_txn_wdata"}, t.data, e.data);
    end
    log_q.delete();
    check_outputs(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_address"}, avm_if.avm_address, 32'h0);
    check({tag, "_read"}, avm_if.avm_read, 1'b0);
    check({tag, "_write"}, avm_if.avm_write, 1'b0);
    check({tag, "_writedata"}, avm_if.avm_writedata, 32'h0);
    check({tag, "_mondreg"}, MonDReg, 32'h0);
    check({tag, "_ready"}, monitor_ready, 1'b0);
    check({tag, "_error"}, monitor_error, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int   cyc;
    int   rd_cnt;
    txn_t t;
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("byteenable", avm_if.avm_byteenable, 4'hF);
    reset_n = 1'b1;
    @(negedge clk);

    // Best-case read of a known word.
    slave_mem[32'h1000] = 32'hDEAD_BEEF;
    model_mem[32'h1000] = 32'hDEAD_BEEF;
    s_wait = 0; s_lat = 1;
    run("t1", K_A, make_a(32'h0000_1000, 0, 1, 0), 0, '0, cyc);
    check("t1_latency", cyc, 3);
    check("t1_mondreg_const", MonDReg, 32'hDEAD_BEEF);

    // Auto-increment writes with two wait states each, then read back at 200C.
    run("t2_load", K_A, make_a(32'h0000_2000, 1, 0, 0), 0, '0, cyc);
    s_wait = 2;
    run("t2_w1", K_B, make_b(32'h1), 0, '0, cyc);
    run("t2_w2", K_B, make_b(32'h2), 0, '0, cyc);
    run("t2_w3", K_B, make_b(32'h3), 0, '0, cyc);
    s_wait = 0;
    run("t2_rd", K_N, '0, 0, '0, cyc);

    // Strobe while busy: no second request, sticky error; later cleared.
    s_wait = 4;
    run("t3_ovr", K_N, '0, K_N, '0, cyc);
    check("t3_error_set", monitor_error, 1'b1);
    s_wait = 0;
    run("t3_clr", K_A, make_a(32'h0000_5000, 0, 0, 1), 0, '0, cyc);
    check("t3_error_clr", monitor_error, 1'b0);

    // Slave stalls forever: read dropped after 15 cycles.
    s_hang = 1;
    m_addr = 32'h3000; m_autoinc = 0;
    drive(K_A, make_a(32'h0000_3000, 0, 1, 0));
    rd_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (avm_if.avm_read) rd_cnt++;
      if (!busy) break;
      @(negedge clk);
    end
    s_hang = 0;
    m_err = 1; m_ready = 1;
    check("t4_read_cycles", rd_cnt, 15);
    check("t4_no_txn", log_q.size(), 0);
    check_outputs("t4");
    run("t4_after", K_N, '0, 0, '0, cyc);
    run("t4_clr", K_A, make_a(32'h0, 0, 0, 1), 0, '0, cyc);

    // Auto-increment wraps past the top of the address space.
    run("t5_top", K_A, make_a(32'hFFFF_FFFC, 1, 1, 0), 0, '0, cyc);
    run("t5_wrap", K_N, '0, 0, '0, cyc);

    // Reset in RD_WAIT; the late readdatavalid must be ignored.
    s_lat = 6;
    drive(K_A, make_a(32'h0000_4000, 0, 1, 0));
    @(negedge clk);
    check("t6_busy_before", busy, 1'b1);
    check("t6_in_rd_wait", avm_if.avm_read, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("t6_reset");
    reset_n = 1'b1;
    repeat (7) @(negedge clk);
    check("t6_txn_count", log_q.size(), 1);
    if (log_q.size() > 0) begin
      t = log_q.pop_front();
      check("t6_txn_addr", t.addr, 32'h4000);
    end
    log_q.delete();
    check_all_zero("t6_post");
    model_reset();

    // Randomized command stream.
    for (int n = 0; n < 60; n++) begin
      int          kind, xk;
      logic [37:0] j, xj;
      logic [31:0] a;
      s_wait = $urandom_range(0, 3);
      s_lat  = $urandom_range(0, 3);
      kind   = $urandom_range(1, 3);
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                      : 32'($urandom);
      if (kind == K_A) j = make_a(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                  ($urandom_range(0, 3) == 0));
      else if (kind == K_B) j = make_b(32'($urandom));
      else j = 38'({$urandom, $urandom});
      xk = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      xj = make_a(32'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      run("rnd", kind, j, xk, xj, cyc);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
